// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Operands above MAX_VAL saturate to 9999 and raise ovf_o; latency is fixed either way.
module bin_to_bcd_seq #(
  parameter int WIDTH   = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] bin_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      bcd_o,
  output logic             ovf_o
);

  localparam int              CW    = $clog2(WIDTH + 1);
  localparam logic [0:0]      IDLE  = 1'b0;
  localparam logic [0:0]      SHIFT = 1'b1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [15:0]      adj_s;
  logic [15:0]      scratch_shift_s;

  // Add-3 correction per nibble; no carry crosses nibble boundaries.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj_s[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                (scratch_q[4*gi +: 4] + 4'd3) : scratch_q[4*gi +: 4];
    end
  endgenerate

  assign scratch_shift_s = {adj_s[14:0], bin_q[WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scratch_d  = scratch_q;
    bin_d      = bin_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d      = bin_i;
          scratch_d  = 16'h0000;
          cnt_d      = '0;
          ovf_pend_d = (bin_i > MAX_W);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift_s;
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        // Commit uses the value produced by this final iteration.
        if (cnt_q == LAST) begin
          bcd_d   = ovf_pend_q ? 16'h9999 : scratch_shift_s;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      scratch_q  <= 16'h0000;
      bin_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= 16'h0000;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      bin_q      <= bin_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: table vectors, random values against a decimal-arithmetic
// model, and hand sequences for held start, ignored requests and reset abort.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] bin_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bcd_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.WIDTH(16), .MAX_VAL(9999)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bin_i  (bin_i),
    .start_i(start_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .bcd_o  (bcd_o),
    .ovf_o  (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: saturate, then peel decimal digits with division.
  function automatic logic [16:0] ref_model(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {(v > 9999) ? 1'b1 : 1'b0, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // One conversion; lat counts edges after the accept edge until done_o is seen.
  task automatic run_conv(input logic [15:0] v, output logic [15:0] r, output logic o,
                          output int lat, output int busy_cnt);
    @(negedge clk);
    bin_i   = v;
    start_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    bin_i    = 16'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (!done_o && lat < 40) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    r = bcd_o;
    o = ovf_o;
    chk("busy_low_at_done", 32'(busy_o), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 0);
    chk("bcd_held", 32'(bcd_o), 32'(r));
    $display("conv bin=%0d bcd=%h ovf=%0d lat=%0d", v, r, o, lat);
  endtask

  logic [15:0] r;
  logic        o;
  int          lat, bcnt;
  logic [16:0] m;

  initial begin
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 1'b0};
    vecs[2] = '{16'd9,     16'h0009, 1'b0};
    vecs[3] = '{16'd10,    16'h0010, 1'b0};
    vecs[4] = '{16'd9999,  16'h9999, 1'b0};
    vecs[5] = '{16'd4095,  16'h4095, 1'b0};
    vecs[6] = '{16'd10000, 16'h9999, 1'b1};
    vecs[7] = '{16'd65535, 16'h9999, 1'b1};
    vecs[8] = '{16'd42,    16'h0042, 1'b0};
    vecs[9] = '{16'd100,   16'h0100, 1'b0};

    rst_n   = 1'b1;
    start_i = 1'b0;
    bin_i   = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_bcd",  32'(bcd_o),  0);
    chk("rst_ovf",  32'(ovf_o),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, r, o, lat, bcnt);
      chk("tbl_bcd", 32'(r), 32'(vecs[i].bcd));
      chk("tbl_ovf", 32'(o), 32'(vecs[i].ovf));
      chk("tbl_latency", 32'(lat), 16);
      chk("tbl_busy_cycles", 32'(bcnt), 16);
    end

    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
      m = ref_model(32'(v));
      run_conv(v, r, o, lat, bcnt);
      chk("rnd_bcd", 32'(r), 32'(m[15:0]));
      chk("rnd_ovf", 32'(o), 32'(m[16]));
      chk("rnd_latency", 32'(lat), 16);
    end

    // start_i held high: one conversion every 17 cycles.
    begin
      int   pos[$];
      logic prev;
      prev = 1'b0;
      @(negedge clk);
      bin_i   = 16'd7;
      start_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done_o) begin
          pos.push_back(c);
          chk("held_bcd", 32'(bcd_o), 32'h0007);
        end
        chk("done_not_double", 32'(prev & done_o), 0);
        prev = done_o;
      end
      start_i = 1'b0;
      chk("held_count", 32'(pos.size()), 3);
      if (pos.size() > 0) chk("held_first", 32'(pos[0]), 16);
      for (int k = 1; k < pos.size(); k++) chk("held_spacing", 32'(pos[k] - pos[k-1]), 17);
      $display("held start done pulses=%0d", pos.size());
      repeat (40) @(negedge clk);
    end

    // Requests mid-conversion and on the commit edge are dropped.
    begin
      int dcount;
      dcount = 0;
      @(negedge clk);
      bin_i   = 16'd321;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        start_i = (k == 5 || k == 16);
        if (k == 5) bin_i = 16'd999;
        @(negedge clk);
        if (done_o) begin
          dcount++;
          chk("ign_bcd", 32'(bcd_o), 32'h0321);
        end
      end
      start_i = 1'b0;
      chk("ign_done_count", 32'(dcount), 1);
      chk("ign_bcd_hold", 32'(bcd_o), 32'h0321);
      chk("ign_idle", 32'(busy_o), 0);
      $display("ignored requests done pulses=%0d bcd=%h", dcount, bcd_o);
    end

    // Abort: leave ovf_o set first so the reset visibly clears it.
    run_conv(16'd65535, r, o, lat, bcnt);
    chk("pre_abort_ovf", 32'(o), 1);
    begin
      int dcount;
      dcount = 0;
      @(negedge clk);
      bin_i   = 16'd5678;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy_o), 0);
      chk("abort_done", 32'(done_o), 0);
      chk("abort_bcd",  32'(bcd_o),  0);
      chk("abort_ovf",  32'(ovf_o),  0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done_o) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 0);
      chk("abort_bcd_after", 32'(bcd_o), 0);
      $display("abort done pulses=%0d bcd=%h", dcount, bcd_o);
    end
    run_conv(16'd5678, r, o, lat, bcnt);
    chk("post_abort_bcd", 32'(r), 32'h5678);
    chk("post_abort_ovf", 32'(o), 0);
    chk("post_abort_latency", 32'(lat), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
